// File: rtl/scoreboard_register_file.sv
// Register file with N combinational read ports, one write-back port and a per-register busy scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward the write-back value to same-cycle reads.
module scoreboard_register_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int ADDR_WIDTH     = $clog2(NUM_REGS),
    parameter int NUM_READ_PORTS = 2,
    parameter int ZERO_REG       = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_address,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ_PORTS-1:0]            read_busy,
    input  logic [ADDR_WIDTH-1:0]                write_address,
    input  logic [DATA_WIDTH-1:0]                write_back_data,
    input  logic                                 write_register_enable,
    input  logic [ADDR_WIDTH-1:0]                issue_address,
    input  logic                                 issue_enable,
    output logic [ADDR_WIDTH:0]                  busy_count
);

    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);

    // An index names a real, writable register: in range and not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_W) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [ADDR_WIDTH:0]   busy_count_q;
    logic [ADDR_WIDTH:0]   busy_count_d;

    logic write_ok;
    logic issue_ok;
    logic busy_set;
    logic busy_clr;

    assign write_ok = write_register_enable && addr_ok(write_address);
    assign issue_ok = issue_enable && addr_ok(issue_address);

    always_comb begin
        regs_d   = regs_q;
        busy_d   = busy_q;
        busy_set = 1'b0;
        busy_clr = 1'b0;
        if (write_ok) begin
            regs_d[write_address] = write_back_data;
            // A same-cycle issue to this register is a newer producer, so busy survives.
            if (busy_q[write_address] && !(issue_ok && (issue_address == write_address))) begin
                busy_d[write_address] = 1'b0;
                busy_clr              = 1'b1;
            end
        end
        if (issue_ok) begin
            busy_d[issue_address] = 1'b1;
            busy_set              = !busy_q[issue_address];
        end
        busy_count_d = busy_count_q + (ADDR_WIDTH+1)'(busy_set) - (ADDR_WIDTH+1)'(busy_clr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q       <= '{default: '0};
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic                  ra_ok;
        assign ra    = read_address[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign ra_ok = addr_ok(ra);
`ifdef REGFILE_BYPASS_EN
        logic fwd;
        assign fwd = write_ok && (write_address == ra);
        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] =
            fwd ? write_back_data : (ra_ok ? regs_q[ra] : '0);
        assign read_busy[p] =
            fwd ? (issue_ok && (issue_address == ra)) : (ra_ok && busy_q[ra]);
`else
        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = ra_ok ? regs_q[ra] : '0;
        assign read_busy[p] = ra_ok && busy_q[ra];
`endif
    end

endmodule
